// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and
// the helper that sizes its cycle counter.
package reset_seq_pkg;

   localparam logic [1:0] ST_ASSERT  = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                             input int unsigned stage_cycles);
      int unsigned longest;
      longest = (hold_cycles > stage_cycles) ? hold_cycles : stage_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchronizer followed by a rising-edge detector for an
// asynchronous level input such as a push button.
module sync_rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   // One-cycle pulse; a level held high produces a single pulse.
   assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all domains in reset, then releases them
// one by one in ascending order; a button press restarts the sequence.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned N_DOMAINS    = 3,
   parameter int unsigned HOLD_CYCLES  = 16,
   parameter int unsigned STAGE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sw_rst_req,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic                 ready
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_CYCLES);
   localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOMAINS - 1);

   logic                 sw_rise;
   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
   logic                 ready_q, ready_d;

   sync_rise_detect u_sw_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sw_rst_req),
      .rise (sw_rise)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      if (sw_rise) begin
         state_d   = ST_ASSERT;
         cnt_d     = '0;
         idx_d     = '0;
         rst_out_d = '1;
         ready_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               rst_out_d = '1;
               ready_d   = 1'b0;
               if (cnt_q == HOLD_LAST) begin
                  cnt_d        = '0;
                  rst_out_d[0] = 1'b0;
                  if (N_DOMAINS == 1) begin
                     state_d = ST_DONE;
                     ready_d = 1'b1;
                  end else begin
                     state_d = ST_RELEASE;
                     idx_d   = IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               // idx_q names the next domain to release.
               if (cnt_q == STAGE_LAST) begin
                  cnt_d = '0;
                  for (int unsigned i = 0; i < N_DOMAINS; i++) begin
                     if (idx_q == IDX_W'(i)) rst_out_d[i] = 1'b0;
                  end
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_DONE;
                     ready_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               cnt_d = '0;
            end
            default: begin
               state_d   = ST_ASSERT;
               cnt_d     = '0;
               idx_d     = '0;
               rst_out_d = '1;
               ready_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
      end
   end

   assign rst_out = rst_out_q;
   assign ready   = ready_q;

endmodule
